// File: rtl/uart_pkg.sv
// Shared definitions for the host-link UART receiver: state encoding, frame width
// and the clocks-per-bit helper.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    function automatic int unsigned baud_cnt_end(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus falling-edge detect.
// All flops reset to the idle-high line level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_pin,
    output logic rx_s,
    output logic fall
);

    logic meta;
    logic rx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            meta <= rx_pin;
            rx_s <= meta;
            rx_d <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: start-bit glitch filter, centre sampling of 8 data bits
// LSB-first, stop-bit check with frame_err and break hold-off. All outputs registered.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic       rx_pin,
    output logic       uart_flag,
    output logic [7:0] uart_data,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned BAUD_CNT_END  = baud_cnt_end(CLK_FREQ, BAUD);
    localparam int unsigned BAUD_CNT_HALF = BAUD_CNT_END / 2;
    localparam int unsigned CNT_W         = $clog2(BAUD_CNT_END);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_END - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_CNT_HALF - 1);

    generate
        if (BAUD_CNT_END < 16) begin : g_baud_check
            $error("uart_byte_rx: CLK_FREQ/BAUD must be at least 16");
        end
    endgenerate

    rx_state_t            state;
    rx_state_t            state_next;
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;
    logic                 fall;
    logic                 mid_tick;
    logic                 bit_tick;

    uart_rx_sync u_sync (
        .clk    (sclk),
        .rst    (s_rst),
        .rx_pin (rx_pin),
        .rx_s   (rx_s),
        .fall   (fall)
    );

    assign mid_tick = (baud_cnt == CNT_MID);
    assign bit_tick = (baud_cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fall) state_next = START;
            START:   if (mid_tick) state_next = rx_s ? IDLE : DATA;
            DATA:    if (bit_tick && bit_cnt == 3'd7) state_next = STOP;
            STOP:    if (bit_tick) state_next = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (s_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            uart_data <= '0;
            uart_flag <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            uart_flag <= (state == STOP) && bit_tick && rx_s;
            frame_err <= (state == STOP) && bit_tick && !rx_s;
            rx_busy   <= (state_next != IDLE);

            // DATA stays in one state across bits, so the bit boundary also restarts the count.
            if (state_next != state || bit_tick) baud_cnt <= '0;
            else                                 baud_cnt <= baud_cnt + 1'b1;

            if (state == START) begin
                bit_cnt <= '0;
            end else if (state == DATA && bit_tick) begin
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 3'd1;
            end

            if (state == STOP && bit_tick && rx_s) uart_data <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomised and directed bench for uart_byte_rx (16 clk/bit), checked against a
// line-level model that samples the driven waveform at ideal bit-centre offsets.
module tb_uart_byte_rx;

    localparam int END  = 16;
    localparam int HALF = 8;

    logic       sclk = 1'b0;
    logic       s_rst = 1'b1;
    logic       rx_pin = 1'b1;
    logic       uart_flag;
    logic [7:0] uart_data;
    logic       frame_err;
    logic       rx_busy;

    int n_checks = 0;
    int n_pass   = 0;

    bit         line[$];
    int         exp_t[$];
    int         exp_k[$];
    logic [7:0] exp_d[$];
    int         obs_t[$];
    int         obs_k[$];
    logic [7:0] obs_d[$];
    logic [7:0] model_data = 8'h00;
    int         busy_cycles;

    uart_byte_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
        .sclk      (sclk),
        .s_rst     (s_rst),
        .rx_pin    (rx_pin),
        .uart_flag (uart_flag),
        .uart_data (uart_data),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 sclk = ~sclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit at(input int k);
        return (k < line.size()) ? line[k] : 1'b1;
    endfunction

    function automatic void add_level(input bit v, input int n);
        for (int i = 0; i < n; i++) line.push_back(v);
    endfunction

    function automatic void add_frame(input logic [7:0] d, input bit stop, input int period);
        add_level(1'b0, period);
        for (int k = 0; k < 8; k++) add_level(d[k], period);
        add_level(stop, period);
    endfunction

    // Receiver view of the line: a 1->0 step arms a frame; the start bit must still be
    // low HALF clocks later; bit k is read HALF+END*(k+1) clocks after the edge.
    // Outputs appear 3 clocks after the sampled line value (2 sync + 1 register).
    function automatic void model(input int from);
        int j = from;
        bit prev = 1'b1;
        exp_t.delete(); exp_k.delete(); exp_d.delete();
        while (j < line.size()) begin
            if (prev && !at(j)) begin
                if (at(j + HALF)) begin
                    j = j + HALF + 1;
                    prev = 1'b1;
                end else begin
                    logic [7:0] d;
                    int s;
                    for (int k = 0; k < 8; k++) d[k] = at(j + HALF + END * (k + 1));
                    s = j + HALF + 9 * END;
                    if (at(s)) begin
                        model_data = d;
                        exp_t.push_back(s + 3); exp_k.push_back(1); exp_d.push_back(d);
                        j = s + 1;
                        prev = 1'b1;
                    end else begin
                        int m = s + 1;
                        exp_t.push_back(s + 3); exp_k.push_back(2); exp_d.push_back(model_data);
                        while (!at(m)) m++;
                        j = m + 1;
                        prev = 1'b1;
                    end
                end
            end else begin
                prev = at(j);
                j++;
            end
        end
    endfunction

    task automatic run_line(input string name, input int from, input int rst_at);
        int overlap = 0;
        int n_min;
        add_level(1'b1, 40);
        if (rst_at >= 0) model_data = 8'h00;
        model(from);
        obs_t.delete(); obs_k.delete(); obs_d.delete();
        busy_cycles = 0;
        for (int n = 0; n < line.size() + 4; n++) begin
            @(negedge sclk);
            if (n > 0) begin
                if (uart_flag) begin obs_t.push_back(n); obs_k.push_back(1); obs_d.push_back(uart_data); end
                if (frame_err) begin obs_t.push_back(n); obs_k.push_back(2); obs_d.push_back(uart_data); end
                if (uart_flag && frame_err) overlap++;
                if (rx_busy) busy_cycles++;
                if (n == rst_at + 1) begin
                    check_val({name, "_rst_flag"}, uart_flag, 0);
                    check_val({name, "_rst_err"},  frame_err, 0);
                    check_val({name, "_rst_busy"}, rx_busy,   0);
                    check_val({name, "_rst_data"}, uart_data, 0);
                end
            end
            rx_pin = (n < line.size()) ? line[n] : 1'b1;
            s_rst  = (n == rst_at);
        end
        s_rst = 1'b0;
        check_val({name, "_overlap"}, overlap, 0);
        check_val({name, "_events"}, obs_t.size(), exp_t.size());
        n_min = (obs_t.size() < exp_t.size()) ? obs_t.size() : exp_t.size();
        for (int i = 0; i < n_min; i++) begin
            check_val($sformatf("%s_ev%0d_time", name, i), obs_t[i], exp_t[i]);
            check_val($sformatf("%s_ev%0d_kind", name, i), obs_k[i], exp_k[i]);
            check_val($sformatf("%s_ev%0d_data", name, i), obs_d[i], exp_d[i]);
        end
        check_val({name, "_final_data"}, uart_data, model_data);
        line.delete();
    endtask

    initial begin
        s_rst  = 1'b1;
        rx_pin = 1'b1;
        repeat (3) @(negedge sclk);
        check_val("reset_flag", uart_flag, 0);
        check_val("reset_data", uart_data, 0);
        check_val("reset_err",  frame_err, 0);
        check_val("reset_busy", rx_busy,   0);
        s_rst = 1'b0;

        add_level(1'b1, 5); add_frame(8'hAA, 1'b1, END);
        run_line("aa", 0, -1);

        add_frame(8'h55, 1'b1, END); add_frame(8'h01, 1'b1, END);
        run_line("b2b", 0, -1);

        add_level(1'b1, 5); add_level(1'b0, 4);
        run_line("glitch", 0, -1);
        check_val("glitch_busy", busy_cycles, HALF);

        add_frame(8'h3C, 1'b0, END); add_level(1'b0, 40); add_level(1'b1, 10);
        add_frame(8'hAA, 1'b1, END);
        run_line("break", 0, -1);

        // Reset lands mid bit 4 of the F0 frame (frame starts at index 5).
        add_level(1'b1, 5); add_frame(8'hF0, 1'b1, END); add_level(1'b1, 20);
        add_frame(8'h12, 1'b1, END);
        run_line("rst", 5 + END * 5 + HALF + 1, 5 + END * 5 + HALF);

        // A 15-clk period drifts past the sample point by bit 6; the model follows the line.
        add_level(1'b1, 5); add_frame(8'hA5, 1'b1, 17); add_level(1'b1, 10);
        add_frame(8'hA5, 1'b1, 15);
        run_line("drift", 0, -1);

        for (int f = 0; f < 10; f++) begin
            logic [7:0] d;
            bit stop;
            d = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            add_level(1'b1, $urandom_range(1, 12));
            if ($urandom_range(0, 3) == 0) begin
                add_level(1'b0, $urandom_range(1, 6));
                add_level(1'b1, 12);
            end
            add_frame(d, stop, END);
            if (!stop) add_level(1'b0, $urandom_range(0, 30));
        end
        run_line("rand", 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
